// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage config: skid register state encoding, active-high
// constants, and the decode from state to handshake/occupancy flags.
package pipe_skid_reg_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic TRUE       = 1'b1;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic [1:0] count;
  } skid_flags_t;

  // Flags are registered beside the state, so they are always derived from
  // the state being entered and never from live handshake inputs.
  function automatic skid_flags_t flags_of(input skid_state_e state);
    skid_flags_t flags;
    case (state)
      StOne:   flags = '{in_ready: TRUE,  out_valid: TRUE,  count: 2'd1};
      StTwo:   flags = '{in_ready: ~TRUE, out_valid: TRUE,  count: 2'd2};
      default: flags = '{in_ready: TRUE,  out_valid: ~TRUE, count: 2'd0};
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register for a pipeline boundary: main drives the output,
// skid absorbs the one payload accepted while downstream stalls.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  skid_state_e       r_state;
  skid_flags_t       r_flags;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;

  logic w_accept;
  logic w_release;

  assign w_accept  = in_valid & r_flags.in_ready;
  assign w_release = r_flags.out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state <= StEmpty;
      r_flags <= flags_of(StEmpty);
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else if (flush == TRUE) begin
      // Flush wins over a same-edge accept: the offered payload is dropped.
      r_state <= StEmpty;
      r_flags <= flags_of(StEmpty);
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state <= StOne;
            r_flags <= flags_of(StOne);
            r_main  <= in_data;
          end
        end
        StOne: begin
          if (w_accept && w_release) begin
            r_main <= in_data;
          end else if (w_accept) begin
            r_state <= StTwo;
            r_flags <= flags_of(StTwo);
            r_skid  <= in_data;
          end else if (w_release) begin
            r_state <= StEmpty;
            r_flags <= flags_of(StEmpty);
          end
        end
        StTwo: begin
          if (w_release) begin
            r_state <= StOne;
            r_flags <= flags_of(StOne);
            r_main  <= r_skid;
          end
        end
        default: begin
          r_state <= StEmpty;
          r_flags <= flags_of(StEmpty);
          r_main  <= FLUSH_VAL;
          r_skid  <= FLUSH_VAL;
        end
      endcase
    end
  end

  assign in_ready  = r_flags.in_ready;
  assign out_valid = r_flags.out_valid;
  assign count     = r_flags.count;
  // main may hold a released payload while empty; mask it off.
  assign out_data  = r_flags.out_valid ? r_main : FLUSH_VAL;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized bench for pipe_skid_reg against a queue model, plus directed
// scenarios with literal expectations.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] FV = 64'hDEAD_BEEF_0000_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] q[$];

  pipe_skid_reg #(
    .DATA_W   (DW),
    .FLUSH_VAL(FV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model view: occupancy is the queue depth, head is what downstream sees.
  task automatic check_model();
    check("model.count", DW'(count), DW'(q.size()));
    check("model.in_ready", DW'(in_ready), DW'(q.size() < 2));
    check("model.out_valid", DW'(out_valid), DW'(q.size() > 0));
    check("model.out_data", out_data, (q.size() > 0) ? q[0] : FV);
  endtask

  task automatic model_edge();
    if (flush) begin
      q.delete();
    end else begin
      bit acc;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
  endtask

  // Called #1 after an edge: drive, compare, then advance one edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_lit(input string tag, input logic [1:0] c, input logic ir, input logic ov,
                           input logic [DW-1:0] od);
    check({tag, ".count"}, DW'(count), DW'(c));
    check({tag, ".in_ready"}, DW'(in_ready), DW'(ir));
    check({tag, ".out_valid"}, DW'(out_valid), DW'(ov));
    check({tag, ".out_data"}, out_data, od);
  endtask

  initial begin
    #12;
    check_lit("reset", 2'd0, 1'b1, 1'b0, FV);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Streaming, one-cycle latency, count pinned at 1.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, DW'(i), 1'b1, 1'b0);
      check_lit("stream", 2'd1, 1'b1, 1'b1, DW'(i));
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_lit("drain", 2'd0, 1'b1, 1'b0, FV);

    // Backpressure: 0xC offered while full stays upstream.
    cycle(1'b1, 64'hA, 1'b0, 1'b0);
    check_lit("bp.a", 2'd1, 1'b1, 1'b1, 64'hA);
    cycle(1'b1, 64'hB, 1'b0, 1'b0);
    check_lit("bp.b", 2'd2, 1'b0, 1'b1, 64'hA);
    cycle(1'b1, 64'hC, 1'b0, 1'b0);
    check_lit("bp.c", 2'd2, 1'b0, 1'b1, 64'hA);
    cycle(1'b1, 64'hC, 1'b1, 1'b0);
    check_lit("bp.out_b", 2'd1, 1'b1, 1'b1, 64'hB);
    cycle(1'b1, 64'hC, 1'b1, 1'b0);
    check_lit("bp.out_c", 2'd1, 1'b1, 1'b1, 64'hC);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_lit("bp.empty", 2'd0, 1'b1, 1'b0, FV);

    // Flush while full with a payload offered.
    cycle(1'b1, 64'h11, 1'b0, 1'b0);
    cycle(1'b1, 64'h22, 1'b0, 1'b0);
    check_lit("fl.full", 2'd2, 1'b0, 1'b1, 64'h11);
    cycle(1'b1, 64'hD, 1'b0, 1'b1);
    check_lit("fl.after", 2'd0, 1'b1, 1'b0, FV);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_lit("fl.no_d", 2'd0, 1'b1, 1'b0, FV);

    // Async reset between edges while full.
    cycle(1'b1, 64'h33, 1'b0, 1'b0);
    cycle(1'b1, 64'h44, 1'b0, 1'b0);
    check_lit("ar.full", 2'd2, 1'b0, 1'b1, 64'h33);
    #2;
    rst = 1'b1;
    #1;
    check_lit("ar.now", 2'd0, 1'b1, 1'b0, FV);
    q.delete();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 64'h55, 1'b0, 1'b0);
    check_lit("ar.first", 2'd1, 1'b1, 1'b1, 64'h55);

    // Random traffic with occasional flush.
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
